// File: rtl/fetch_pkg.sv
// Shared defaults and types for the fetch sequencer.
// Included by fetch_ring and fetch_sequencer.
package fetch_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ILEN_DEF  = 32;
  localparam int STEP_DEF  = 4;
  localparam int DEPTH_DEF = 4;
  localparam int DROP_W    = 16;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h100;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_ring.sv
// In-order {pc,instr} ring with issue, fill and read pointers.
// A flush collapses the ring to the post-read pointer.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = ptr_w(DEPTH),
  localparam int IW   = PW - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic            fill_en,
  input  logic [ILEN-1:0] fill_instr,
  input  logic            pop,
  input  logic            flush,
  output logic [PW-1:0]   wr_ptr,
  output logic [PW-1:0]   fill_ptr,
  output logic [PW-1:0]   rd_ptr,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [ILEN-1:0] ins_mem [DEPTH];
  logic [PW-1:0]   rd_nxt;

  assign rd_nxt    = rd_ptr + PW'(pop);
  assign out_pc    = pc_mem[rd_ptr[IW-1:0]];
  assign out_instr = ins_mem[rd_ptr[IW-1:0]];

  // pointer update; flush keeps this cycle's read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else if (flush) begin
      wr_ptr   <= rd_nxt;
      fill_ptr <= rd_nxt;
      rd_ptr   <= rd_nxt;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push);
      fill_ptr <= fill_ptr + PW'(fill_en);
      rd_ptr   <= rd_nxt;
    end
  end

  // entry storage, written at issue and at response
  always_ff @(posedge clk) begin
    if (push)
      pc_mem[wr_ptr[IW-1:0]] <= push_pc;
    if (fill_en)
      ins_mem[fill_ptr[IW-1:0]] <= fill_instr;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC generator and in-order fetch sequencer with redirect flush.
// Optional misaligned-redirect trap: define PC_TRAP_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ILEN  = ILEN_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR =
    XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR =
    XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            out_ready
`ifdef PC_TRAP_EN
  ,
  output logic            trap
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  localparam logic [XLEN-1:0] MASK = XLEN'(STEP - 1);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   target;
  logic [DROP_W-1:0] drop_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     fill_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     occ;
  logic [PW-1:0]     inflight;
  logic              req_fire;
  logic              rsp_take;
  logic              pop;

  assign occ      = wr_ptr - rd_ptr;
  assign inflight = wr_ptr - fill_ptr;
  assign req_valid = ~rst & en & ~redirect_valid
                   & (occ != FULL);
  assign req_addr = pc_q;
  assign req_fire = req_valid & req_ready;
  assign rsp_take = rsp_valid & ~redirect_valid
                  & (drop_cnt == '0);
  assign out_valid = fill_ptr != rd_ptr;
  assign pop       = out_valid & out_ready;

`ifdef PC_TRAP_EN
  logic misal;
  assign misal  = |(redirect_pc & MASK);
  assign target = misal ? TRAP_VECTOR : redirect_pc;

  // one-cycle pulse after a misaligned redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap <= 1'b0;
    else     trap <= redirect_valid & misal;
  end
`else
  assign target = redirect_pc & ~MASK;
`endif

  // program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc_q <= RESET_VECTOR;
    else if (redirect_valid) pc_q <= target;
    else if (req_fire)       pc_q <= pc_q + XLEN'(STEP);
  end

  // responses still owed to flushed requests; a
  // response in the redirect cycle retires one of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (redirect_valid)
      drop_cnt <= drop_cnt + DROP_W'(inflight)
                - DROP_W'(rsp_valid);
    else if (rsp_valid && drop_cnt != '0)
      drop_cnt <= drop_cnt - DROP_W'(1);
  end

  fetch_ring #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .push       (req_fire),
    .push_pc    (pc_q),
    .fill_en    (rsp_take),
    .fill_instr (rsp_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .wr_ptr     (wr_ptr),
    .fill_ptr   (fill_ptr),
    .rd_ptr     (rd_ptr),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised scoreboard bench for fetch_sequencer.
// Model: per-redirect epochs and a program-order queue.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
`ifdef PC_TRAP_EN
  logic        trap;
`endif

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
`ifdef PC_TRAP_EN
    ,
    .trap           (trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mem_t;

  mem_t        mq[$];
  logic [31:0] exp_pc[$];
  logic [31:0] pc_m;
  int          avail;
  int          epoch;
  int          cyc;
  int          delay_now;
  int          rsp_ep_now;
  logic        trap_exp;
  int          n_chk;
  int          n_pass;

  function automatic logic [31:0] instr_of(
    input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h",
                  name, cyc, act, req);
  endtask

  // monitor: compare against model, then advance it
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_req_addr", req_addr, 0);
      pc_m = 32'h0;
      exp_pc.delete();
      mq.delete();
      avail = 0;
      epoch++;
      trap_exp = 1'b0;
    end else begin
      chk("out_valid", 32'(out_valid),
          32'(avail > 0));
      if (out_valid && exp_pc.size() > 0) begin
        chk("out_pc", out_pc, exp_pc[0]);
        chk("out_instr", out_instr,
            instr_of(exp_pc[0]));
      end
      chk("req_valid", 32'(req_valid),
          32'(en && !redirect_valid &&
              exp_pc.size() < 4));
      if (req_valid)
        chk("req_addr", req_addr, pc_m);
`ifdef PC_TRAP_EN
      chk("trap", 32'(trap), 32'(trap_exp));
`endif
      if (out_valid && out_ready &&
          exp_pc.size() > 0) begin
        void'(exp_pc.pop_front());
        if (avail > 0) avail--;
      end
      trap_exp = 1'b0;
      if (redirect_valid) begin
        exp_pc.delete();
        avail = 0;
        epoch++;
`ifdef PC_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          pc_m = 32'h100;
          trap_exp = 1'b1;
        end else begin
          pc_m = redirect_pc;
        end
`else
        pc_m = redirect_pc & ~32'h3;
`endif
      end else begin
        if (rsp_valid && rsp_ep_now == epoch)
          avail++;
        if (req_valid && req_ready) begin
          exp_pc.push_back(pc_m);
          mq.push_back('{addr: req_addr, ep: epoch,
                         due: cyc + 1 + delay_now});
          pc_m = pc_m + 32'h4;
        end
      end
    end
  end

  // driver: phased then random stimulus, plus memory
  initial begin
    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0;
    out_ready = 1'b0; cyc = 0; delay_now = 0;
    rsp_ep_now = -1; epoch = 0; n_chk = 0;
    n_pass = 0; avail = 0; pc_m = '0;
    trap_exp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      rst = (c < 3) || (c >= 2000 && c < 2002);
      en = 1'b1;
      req_ready = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = $urandom;
      delay_now = 0;
      if (c >= 40 && c < 60) out_ready = 1'b0;
      if (c >= 80 && c < 130) begin
        delay_now = 2;
        if (c == 86) begin
          redirect_valid = 1'b1;
          redirect_pc = 32'h200;
        end
        if (c == 100) begin
          redirect_valid = 1'b1;
          redirect_pc = 32'hFFFF_FFF8;
        end
        if (c == 115) begin
          redirect_valid = 1'b1;
          redirect_pc = 32'h202;
        end
      end
      if (c >= 130) begin
        en = $urandom_range(7) != 0;
        req_ready = $urandom_range(3) != 0;
        out_ready = $urandom_range(3) != 0;
        delay_now = $urandom_range(3);
        redirect_valid = $urandom_range(11) == 0;
        if ($urandom_range(3) != 0)
          redirect_pc[1:0] = 2'b00;
        if ($urandom_range(15) == 0)
          redirect_pc = 32'hFFFF_FFF8;
      end
      if (rst) redirect_valid = 1'b0;
      if (!rst && mq.size() > 0 &&
          mq[0].due <= c) begin
        rsp_valid = 1'b1;
        rsp_data = instr_of(mq[0].addr);
        rsp_ep_now = mq[0].ep;
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data = '0;
        rsp_ep_now = -1;
      end
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
